// File: rtl/herloa_mon_pkg.sv
// Shared types and width helpers for the HERLOA error-statistics monitor.
package herloa_mon_pkg;

    // Window-control FSM encoding; exported on the top's fsm_state port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Error counter must reach SAMPLES itself, hence the extra bit.
    function automatic int cnt_width(input int samples);
        return $clog2(samples) + 1;
    endfunction

    // ED sum holds SAMPLES * (2^(N+1)-1) without wrapping.
    function automatic int sum_width(input int n, input int samples);
        return n + 1 + $clog2(samples);
    endfunction

endpackage

// File: rtl/herloa_error_monitor_if.sv
// Sample input channel of the error monitor: operands plus approximate sum.
// Handshake: a sample transfers on a rising clk edge where in_valid && in_ready;
// the producer holds in_a/in_b/in_s stable while in_valid is high and not yet
// accepted; in_ready never depends combinationally on in_valid.
interface herloa_error_monitor_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [N-1:0] in_s;

    modport master (output in_valid, output in_a, output in_b, output in_s, input in_ready);
    modport slave  (input in_valid, input in_a, input in_b, input in_s, output in_ready);
endinterface

// File: rtl/herloa_ed_calc.sv
// Combinational error distance between the exact N+1-bit sum and the
// carry-less approximate sum produced by the adder.
module herloa_ed_calc #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] s,
    output logic [N:0]   ed
);
    logic [N:0] exact;
    logic [N:0] approx;

    // Exact sum keeps its carry; the approximate sum never has one, so an
    // overflowing operand pair always shows up as a non-zero distance.
    always_comb begin
        exact  = {1'b0, a} + {1'b0, b};
        approx = {1'b0, s};
        ed     = (exact >= approx) ? (exact - approx) : (approx - exact);
    end
endmodule

// File: rtl/herloa_error_monitor.sv
// Window-based accuracy monitor for the HERLOA approximate adder: registers
// each accepted sample, computes its ED one cycle later and accumulates
// error count, total, maximum and mean ED over SAMPLES samples.
module herloa_error_monitor
    import herloa_mon_pkg::*;
#(
    parameter int N       = 16,
    parameter int K       = 11,
    parameter int SAMPLES = 256
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    herloa_error_monitor_if.slave               in_if,
    output logic                                busy,
    output logic                                done,
    output logic [cnt_width(SAMPLES)-1:0]       err_count,
    output logic [sum_width(N, SAMPLES)-1:0]    sum_ed,
    output logic [N:0]                          max_ed,
    output logic [N:0]                          mean_ed,
    output logic [7:0]                          cfg_k,
    output state_t                              fsm_state
);
    localparam int LOG = $clog2(SAMPLES);
    localparam int CW  = cnt_width(SAMPLES);
    localparam int SW  = sum_width(N, SAMPLES);

    state_t        state_q;
    state_t        state_d;
    logic          ready;
    logic          clear;
    logic          accept;
    logic [CW-1:0] acc_cnt_q;
    logic          s1_valid_q;
    logic [N-1:0]  s1_a_q;
    logic [N-1:0]  s1_b_q;
    logic [N-1:0]  s1_s_q;
    logic [N:0]    ed;

    herloa_ed_calc #(.N(N)) u_ed_calc (
        .a  (s1_a_q),
        .b  (s1_b_q),
        .s  (s1_s_q),
        .ed (ed)
    );

    assign accept         = in_if.in_valid && ready;
    assign in_if.in_ready = ready;
    assign busy           = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done           = (state_q == ST_DONE);
    assign mean_ed        = sum_ed[SW-1:LOG];
    assign cfg_k          = 8'(K);
    assign fsm_state      = state_q;

    // Window FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state, accumulator clear and ready decode; start only counts in IDLE/DONE.
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        ready   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                ready = 1'b1;
                if (in_if.in_valid && (acc_cnt_q == CW'(SAMPLES - 1))) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Stage-1 sample capture plus the accepted-sample counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_s_q     <= '0;
            acc_cnt_q  <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_a_q    <= in_if.in_a;
                s1_b_q    <= in_if.in_b;
                s1_s_q    <= in_if.in_s;
                acc_cnt_q <= acc_cnt_q + CW'(1);
            end else if (clear) begin
                acc_cnt_q <= '0;
            end
        end
    end

    // Statistics accumulate one edge after capture; clear and a pending
    // stage-1 sample never coincide because clear only fires outside RUN/DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
        end else if (clear) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
        end else if (s1_valid_q) begin
            err_count <= err_count + CW'(|ed);
            sum_ed    <= sum_ed + SW'(ed);
            if (ed > max_ed) max_ed <= ed;
        end
    end
endmodule
